// File: rtl/serial_tx.sv
// MSB-first parallel-to-serial transmitter with a ready/valid load port and gapless back-to-back frames.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after data bit 0.
module serial_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_TX_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
`ifdef SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif
   logic             accept;

   // Ready during the final bit lets the next word start without a bubble.
   assign load_ready = (state_q == IDLE) | last_q;
   assign accept     = load_valid & load_ready;

   assign ser_out    = out_q;
   assign ser_valid  = valid_q;
   assign ser_last   = last_q;
   assign busy       = valid_q;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      valid_d  = valid_q;
      last_d   = last_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            // shreg_q holds the bit on ser_out at its MSB; the next bit sits just below it.
            if (cnt_q != CNT_LAST) begin
               cnt_d   = cnt_q + CW'(1);
               shreg_d = shreg_q << 1;
               out_d   = shreg_q[WIDTH-2];
`ifdef SERIAL_TX_PARITY_EN
               last_d  = 1'b0;
`else
               last_d  = (cnt_q == CNT_LAST - CW'(1));
`endif
            end else begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = PARITY;
               out_d   = parity_q;
               last_d  = 1'b1;
`else
               state_d = IDLE;
               cnt_d   = '0;
               out_d   = 1'b0;
               valid_d = 1'b0;
               last_d  = 1'b0;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
`endif
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase

      // An accept only happens in IDLE or on the last bit, so it overrides the end-of-frame path.
      if (accept) begin
         state_d  = SHIFT;
         shreg_d  = load_data;
         cnt_d    = '0;
         out_d    = load_data[WIDTH-1];
         valid_d  = 1'b1;
         last_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_d = ^load_data;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         out_q    <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a WIDTH=8 and a WIDTH=2 instance, expected bit streams queued on accept.
// Honours SERIAL_TX_PARITY_EN for the expected frame format.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       lv0, lv1;
   logic [7:0] ld0;
   logic [1:0] ld1;
   logic       lr0, so0, sv0, sl0, bz0;
   logic       lr1, so1, sv1, sl1, bz1;

   int n_pass  = 0;
   int n_total = 0;
   int acc0    = 0;
   int acc1    = 0;

   // Each queued item is {bit, last}, one per expected serial cycle.
   logic [1:0] q0[$];
   logic [1:0] q1[$];

   serial_tx #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
      .ser_out(so0), .ser_valid(sv0), .ser_last(sl0), .busy(bz0)
   );

   serial_tx #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
      .ser_out(so1), .ser_valid(sv1), .ser_last(sl1), .busy(bz1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   // Reference frame: data bits MSB first, optional even parity, last flag on the final item.
   function automatic void push_frame(input int i, input logic [31:0] d, input int w);
      logic p;
      logic [1:0] it;
      p = 1'b0;
      for (int k = w - 1; k >= 0; k--) begin
         p  = p ^ d[k];
         it = {d[k], (k == 0) && !PAR};
         if (i == 0) q0.push_back(it); else q1.push_back(it);
      end
      if (PAR) begin
         it = {p, 1'b1};
         if (i == 0) q0.push_back(it); else q1.push_back(it);
      end
   endfunction

   // The model is ready whenever no bits remain queued beyond the one currently shown.
   always @(posedge clk) begin
      if (rst_n) begin
         if (lv0 && q0.size() == 0) begin
            push_frame(0, {24'b0, ld0}, 8);
            acc0++;
         end
         if (lv1 && q1.size() == 0) begin
            push_frame(1, {30'b0, ld1}, 2);
            acc1++;
         end
      end
   end

   task automatic mon(input int i, input logic sv, input logic so, input logic sl,
                      input logic bz, input logic lr);
      logic [1:0] it;
      logic       ev;
      string      tag;
      tag = (i == 0) ? "w8" : "w2";
      ev  = (qsize(i) > 0);
      if (ev) begin
         it = (i == 0) ? q0.pop_front() : q1.pop_front();
         check({sv, so, sl} == {1'b1, it}, {tag, "_ser_bit"}, 32'({sv, so, sl}), 32'({1'b1, it}));
      end else begin
         check({sv, so, sl} == 3'b000, {tag, "_idle_out"}, 32'({sv, so, sl}), 32'd0);
      end
      check(bz == ev, {tag, "_busy"}, 32'(bz), 32'(ev));
      check(lr == (qsize(i) == 0), {tag, "_load_ready"}, 32'(lr), 32'(qsize(i) == 0));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, sv0, so0, sl0, bz0, lr0);
         mon(1, sv1, so1, sl1, bz1, lr1);
      end
   end

   task automatic drive(input int i, input logic v, input logic [31:0] d);
      if (i == 0) begin lv0 = v; ld0 = d[7:0]; end
      else begin lv1 = v; ld1 = d[1:0]; end
   endtask

   // Hold the word valid until the model records an accept, then drop valid.
   task automatic send(input int i, input logic [31:0] d);
      int start;
      int n;
      start = (i == 0) ? acc0 : acc1;
      drive(i, 1'b1, d);
      n = 0;
      while (((i == 0) ? acc0 : acc1) == start && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (((i == 0) ? acc0 : acc1) == start) check(1'b0, "accept_timeout", 32'(n), 32'd100);
      drive(i, 1'b0, d);
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (qsize(i) != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (qsize(i) != 0) check(1'b0, "idle_timeout", 32'(qsize(i)), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rand_run(input int i, input int words);
      int gap;
      for (int k = 0; k < words; k++) begin
         send(i, $urandom);
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            drive(i, 1'($urandom_range(0, 1)), $urandom);
            @(posedge clk);
            #1;
         end
         drive(i, 1'b0, 32'd0);
      end
   endtask

   task automatic reset_checks;
      check({sv0, so0, sl0, bz0} == 4'b0, "w8_reset_out", 32'({sv0, so0, sl0, bz0}), 32'd0);
      check(lr0 == 1'b1, "w8_reset_ready", 32'(lr0), 32'd1);
      check({sv1, so1, sl1, bz1} == 4'b0, "w2_reset_out", 32'({sv1, so1, sl1, bz1}), 32'd0);
      check(lr1 == 1'b1, "w2_reset_ready", 32'(lr1), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      lv0 = 1'b0; ld0 = '0;
      lv1 = 1'b0; ld1 = '0;
      #2;
      reset_checks();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      send(0, 32'hA5);
      wait_idle(0);

      send(0, 32'hFF);
      send(0, 32'h00);
      wait_idle(0);

      // A word offered mid-frame must be refused and leave the frame intact.
      send(0, 32'h96);
      repeat (2) @(posedge clk);
      #1 drive(0, 1'b1, 32'h3C);
      @(posedge clk);
      #1 drive(0, 1'b0, 32'h00);
      wait_idle(0);

      send(0, 32'h07);
      send(0, 32'h03);
      wait_idle(0);

      send(1, 32'h2);
      wait_idle(1);

      fork
         rand_run(0, 40);
         rand_run(1, 40);
      join
      wait_idle(0);
      wait_idle(1);

      // Asynchronous reset between edges in the middle of a frame.
      send(0, 32'hC3);
      send(1, 32'h3);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      reset_checks();
      q0.delete();
      q1.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(0, 32'h5A);
      wait_idle(0);
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
